// File: rtl/ram_skew_reader_if.sv
// Bus bundle for ram_skew_reader: command inputs, RAM port and skewed array feed.
// The slave modport is the reader; the master modport is whoever drives commands and the RAM.
interface ram_skew_reader_if #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8
);
  logic                          start;
  logic [AWIDTH-1:0]             base_addr;
  logic [AWIDTH-1:0]             stride;
  logic [AWIDTH:0]               num_rows;
  logic [AWIDTH-1:0]             ram_addr;
  logic [DESIGN_SIZE-1:0]        ram_we;
  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data;
  logic [DESIGN_SIZE-1:0]        out_valid;
  logic                          busy;
  logic                          done;

  modport master (
    output start, base_addr, stride, num_rows, ram_q,
    input  ram_addr, ram_we, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, base_addr, stride, num_rows, ram_q,
    output ram_addr, ram_we, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/ram_skew_reader.sv
// Reads N strided RAM rows and feeds them to a systolic array edge with a
// per-lane skew: lane i of row k appears i cycles after lane 0 of that row.
module ram_skew_reader #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  ram_skew_reader_if.slave  bus
);

  localparam int CW = $clog2(DESIGN_SIZE + 1);
  localparam logic [AWIDTH:0] ONE_ROW = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [AWIDTH-1:0] stride_q, stride_d;
  logic [AWIDTH:0]   nrows_q, nrows_d;
  logic [AWIDTH:0]   row_q, row_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic              last_row;

  logic                          rd_vld_p0;
  logic                          rd_vld_p1_q;
  logic [DESIGN_SIZE*DWIDTH-1:0] cap_p2_q;
  logic                          cap_vld_p2_q;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data_w;
  logic [DESIGN_SIZE-1:0]        out_valid_w;

  assign last_row = (row_q == nrows_q - ONE_ROW);

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    stride_d   = stride_q;
    nrows_d    = nrows_q;
    row_d      = row_q;
    drain_d    = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          stride_d = bus.stride;
          nrows_d  = bus.num_rows;
          row_d    = '0;
          drain_d  = '0;
          if (bus.num_rows == '0) begin
            state_d = DONE;
          end else begin
            state_d    = READ;
            ram_addr_d = bus.base_addr;
          end
        end
      end
      READ: begin
        row_d = row_q + ONE_ROW;
        if (last_row) begin
          state_d = DRAIN;
        end else begin
          ram_addr_d = ram_addr_q + stride_q;
        end
      end
      DRAIN: begin
        // Last row still has to walk through the full skew before completion.
        if (drain_q == CW'(DESIGN_SIZE)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      stride_q   <= '0;
      nrows_q    <= '0;
      row_q      <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      stride_q   <= stride_d;
      nrows_q    <= nrows_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
    end
  end

  assign rd_vld_p0 = (state_q == READ);

  // p0 -> p1: address issued; p1 -> p2: RAM data captured, zeroed when not a real row
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_vld_p1_q  <= 1'b0;
      cap_p2_q     <= '0;
      cap_vld_p2_q <= 1'b0;
    end else begin
      rd_vld_p1_q  <= rd_vld_p0;
      cap_p2_q     <= rd_vld_p1_q ? bus.ram_q : '0;
      cap_vld_p2_q <= rd_vld_p1_q;
    end
  end

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign out_data_w[DWIDTH-1:0] = cap_p2_q[DWIDTH-1:0];
      assign out_valid_w[0]         = cap_vld_p2_q;
    end else begin : g_delay
      logic [DWIDTH-1:0] dly_q [i];
      logic              dly_vld_q [i];

      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int j = 0; j < i; j++) begin
            dly_q[j]     <= '0;
            dly_vld_q[j] <= 1'b0;
          end
        end else begin
          dly_q[0]     <= cap_p2_q[i*DWIDTH +: DWIDTH];
          dly_vld_q[0] <= cap_vld_p2_q;
          for (int j = 1; j < i; j++) begin
            dly_q[j]     <= dly_q[j-1];
            dly_vld_q[j] <= dly_vld_q[j-1];
          end
        end
      end

      assign out_data_w[i*DWIDTH +: DWIDTH] = dly_q[i-1];
      assign out_valid_w[i]                 = dly_vld_q[i-1];
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = '0;
  assign bus.out_data  = out_data_w;
  assign bus.out_valid = out_valid_w;
  assign bus.busy      = (state_q == READ) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_ram_skew_reader.sv
// Directed bench for ram_skew_reader with a 1-cycle-latency RAM whose row a, lane i holds (a+i) mod 256.
module tb_ram_skew_reader;
  localparam int AW = 10;
  localparam int DS = 16;
  localparam int DW = 8;
  localparam int VW = DS * DW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ram_skew_reader_if #(.AWIDTH(AW), .DESIGN_SIZE(DS), .DWIDTH(DW)) bus ();

  ram_skew_reader #(.AWIDTH(AW), .DESIGN_SIZE(DS), .DWIDTH(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [VW-1:0] ram_row(input int a);
    logic [VW-1:0] r;
    for (int i = 0; i < DS; i++) r[i*DW +: DW] = DW'((a + i) % 256);
    return r;
  endfunction

  always @(posedge clk) bus.ram_q <= ram_row(int'(bus.ram_addr));

  int n_chk = 0;
  int n_fail = 0;
  int prev_addr = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one start in the current cycle (T0) and checks every cycle T0..T0+N+DS+4.
  // s2: cycle offset of an extra start pulse (-1 none); rst_at: cycle offset of a one-cycle reset (-1 none).
  task automatic run(input string tag, input int base, input int str, input int n,
                     input int s2, input int rst_at);
    int            last;
    int            a;
    int            k;
    bit            aborted;
    bit            e_busy;
    bit            e_done;
    logic [VW-1:0] ed;
    logic [DS-1:0] ev;
    last = n + DS + 4;
    bus.base_addr = AW'(base);
    bus.stride    = AW'(str);
    bus.num_rows  = (AW+1)'(n);
    bus.start     = 1'b1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      aborted = (rst_at >= 0) && (t > rst_at);
      if (aborted) a = 0;
      else if (n > 0 && t >= 1) a = (base + ((t <= n) ? t - 1 : n - 1) * str) % 1024;
      else a = prev_addr;
      ed = '0;
      ev = '0;
      if (!aborted) begin
        for (int i = 0; i < DS; i++) begin
          k = t - 3 - i;
          if (k >= 0 && k < n) begin
            ev[i] = 1'b1;
            ed[i*DW +: DW] = DW'((((base + k * str) % 1024) + i) % 256);
          end
        end
      end
      e_busy = !aborted && (n > 0) && (t >= 1) && (t <= n + DS + 1);
      e_done = !aborted && ((n == 0) ? (t == 1) : (t == n + DS + 2));
      chk($sformatf("%s t=%0d ram_addr", tag, t), VW'(bus.ram_addr), VW'(a));
      chk($sformatf("%s t=%0d busy", tag, t), VW'(bus.busy), VW'(e_busy));
      chk($sformatf("%s t=%0d done", tag, t), VW'(bus.done), VW'(e_done));
      chk($sformatf("%s t=%0d ram_we", tag, t), VW'(bus.ram_we), '0);
      chk($sformatf("%s t=%0d out_valid", tag, t), VW'(bus.out_valid), VW'(ev));
      chk($sformatf("%s t=%0d out_data", tag, t), bus.out_data, ed);
      @(posedge clk);
      #1;
      bus.start = (t + 1 == s2);
      if (t + 1 == s2) bus.base_addr = AW'(300);
      resetn = !(t + 1 == rst_at);
    end
    if (rst_at >= 0) prev_addr = 0;
    else if (n > 0) prev_addr = (base + (n - 1) * str) % 1024;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.stride    = '0;
    bus.num_rows  = '0;
    resetn        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ram_addr", VW'(bus.ram_addr), '0);
    chk("reset busy", VW'(bus.busy), '0);
    chk("reset done", VW'(bus.done), '0);
    chk("reset ram_we", VW'(bus.ram_we), '0);
    chk("reset out_valid", VW'(bus.out_valid), '0);
    chk("reset out_data", bus.out_data, '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run("seq16", 0, 1, 16, -1, -1);
    run("wrap", 1020, 3, 4, -1, -1);
    run("n0", 55, 4, 0, -1, -1);
    run("restart_ignored", 100, 2, 5, 5, -1);
    run("midreset", 200, 1, 8, -1, 6);
    run("after_reset", 10, 5, 3, -1, -1);
    run("stride0", 7, 0, 3, -1, -1);
    run("single_row", 512, 9, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_skew_reader.md
RAM_SKEW_READER -- requirements
Module: ram_skew_reader

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 10, RAM address width.
REQ-002 The block SHALL have parameter DESIGN_SIZE, default 16, lanes per RAM word and systolic array edge length.
REQ-003 The block SHALL have parameter DWIDTH, default 8, bits per lane element.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, one-cycle request to begin a read sequence.
REQ-007 The block SHALL have port base_addr, input, AWIDTH, first RAM row address, sampled with start.
REQ-008 The block SHALL have port stride, input, AWIDTH, address increment per row, sampled with start.
REQ-009 The block SHALL have port num_rows, input, AWIDTH+1, number of rows to read (0..2^AWIDTH), sampled with start.
REQ-010 The block SHALL have port ram_addr, output, AWIDTH, drives RAM port address.
REQ-011 The block SHALL have port ram_we, output, DESIGN_SIZE, RAM per-lane write enables, held at all zeros.
REQ-012 The block SHALL have port ram_q, input, DESIGN_SIZE*DWIDTH, RAM read data; lane i is ram_q[i*DWIDTH +: DWIDTH].
REQ-013 The block SHALL have port out_data, output, DESIGN_SIZE*DWIDTH, skewed array feed, same lane packing as ram_q.
REQ-014 The block SHALL have port out_valid, output, DESIGN_SIZE, per-lane valid for out_data.
REQ-015 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until the done cycle.
REQ-016 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-017 The RAM SHALL have a read latency of 1 cycle: ram_q reflects the ram_addr presented in the previous cycle.
REQ-018 The block SHALL implement the FSM states IDLE, READ, DRAIN and DONE; on reset the FSM SHALL be in IDLE.
REQ-019 In IDLE with start=1 (cycle T0), the block SHALL latch base_addr, stride and num_rows (N) and enter READ at T0+1; if N=0 it SHALL enter DONE instead.
REQ-020 In READ, ram_addr SHALL be (base_addr + k*stride) mod 2^AWIDTH at cycle T0+1+k, for k=0..N-1; after the last read the FSM SHALL enter DRAIN.
REQ-021 Element i of row k SHALL appear on out_data lane i with out_valid[i]=1 at cycle T0+3+k+i.
REQ-022 This SHALL be implemented as one capture register followed by an i-stage delay line on lane i.
REQ-023 Lanes not carrying a valid element SHALL output zero data with out_valid[i]=0.
REQ-024 DRAIN SHALL last until the last element (lane DESIGN_SIZE-1, row N-1) is output at T0+N+DESIGN_SIZE+1.
REQ-025 DONE SHALL occupy cycle T0+N+DESIGN_SIZE+2, with done=1 and busy=0 in that cycle; the FSM SHALL return to IDLE next cycle.
REQ-026 For N=0, done SHALL pulse at T0+1, no RAM read SHALL be issued, and out_valid SHALL stay zero.
REQ-027 start SHALL be ignored in READ, DRAIN and DONE; a start in IDLE on the cycle after DONE SHALL be accepted.
REQ-028 Address arithmetic SHALL wrap modulo 2^AWIDTH; stride=0 SHALL re-read base_addr N times.
REQ-029 ram_addr SHALL hold its last value when not in READ.

Reset
REQ-030 While resetn=0 at a clock edge, the block SHALL set the FSM to IDLE and clear to zero: ram_addr, ram_we, out_data, out_valid, busy, done, all delay-line stages and all counters.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence: no done pulse and no further out_valid.

Verification
REQ-032 Directed test: RAM row r lane i = (r+i) mod 256; start with base=0, stride=1, N=16 at T0 -> lane i valid at T0+3+k+i with value (k+i) mod 256; done at T0+34.
REQ-033 Directed test: base=1020, stride=3, N=4 -> ram_addr sequence 1020, 1023, 2, 5.
REQ-034 Directed test: N=0 -> done at T0+1, busy stays 0, out_valid stays 0, ram_addr unchanged.
REQ-035 Directed test: start pulsed again at T0+5 while busy -> ignored, single done at T0+N+18.
REQ-036 Directed test: resetn=0 at T0+6 for one cycle -> all outputs 0 from T0+7, no done, next start accepted normally.
REQ-037 Directed test: stride=0, N=3, base=7 -> ram_addr=7 for three cycles, each lane outputs the same element three consecutive times.
